// File: rtl/qsys_routing_controller_onchip_mem_arb_pkg.sv
// Shared types and default widths for the two-master on-chip memory arbiter.
package qsys_routing_controller_onchip_mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef logic [0:0] req_id_t;

    typedef enum logic [1:0] {
        TXN_NONE = 2'd0,
        TXN_RD   = 2'd1,
        TXN_WR   = 2'd2
    } txn_t;

    // A write wins over a simultaneous read from the same master; the read is dropped.
    function automatic txn_t txn_type(input logic rd, input logic wr);
        if (wr) return TXN_WR;
        if (rd) return TXN_RD;
        return TXN_NONE;
    endfunction

endpackage

// File: rtl/qsys_routing_controller_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant plus a 1-bit priority register.
module qsys_routing_controller_rr_arb2
    import qsys_routing_controller_onchip_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic       grant_valid_c,
    output req_id_t    grant_id_c
);

    // Requester that wins the next contention; it is the one not granted last.
    req_id_t prio_q;

    always_comb begin
        grant_id_c    = req_id_t'(0);
        grant_valid_c = (|req) && !reset;
        if (req == 2'b11) begin
            grant_id_c = prio_q;
        end else if (req[1]) begin
            grant_id_c = req_id_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= req_id_t'(0);
        end else if (grant_valid_c) begin
            prio_q <= ~grant_id_c;
        end
    end

endmodule

// File: rtl/qsys_routing_controller_onchip_mem_arb.sv
// Two-master arbiter in front of a single-port on-chip RAM with 1-cycle read latency.
// Optional grant statistics are enabled by defining ONCHIP_MEM_ARB_STATS_EN.
module qsys_routing_controller_onchip_mem_arb
    import qsys_routing_controller_onchip_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    input  logic                stats_clr,
    output logic [CNT_W-1:0]    grant_cnt0,
    output logic [CNT_W-1:0]    grant_cnt1
);

    txn_t    txn0, txn1, gnt_txn;
    logic    grant_valid_c;
    req_id_t grant_id_c;
    logic    pend_q;
    req_id_t owner_q;

    assign txn0 = txn_type(m0_read, m0_write);
    assign txn1 = txn_type(m1_read, m1_write);

    qsys_routing_controller_rr_arb2 u_arb (
        .clk           (clk),
        .reset         (reset),
        .req           ({txn1 != TXN_NONE, txn0 != TXN_NONE}),
        .grant_valid_c (grant_valid_c),
        .grant_id_c    (grant_id_c)
    );

    // Winner's command onto the RAM port; address/data are don't-care without a grant.
    always_comb begin
        gnt_txn        = txn0;
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        if (grant_id_c == req_id_t'(1)) begin
            gnt_txn        = txn1;
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
        end
        mem_chipselect = grant_valid_c;
        mem_write      = grant_valid_c && (gnt_txn == TXN_WR);
    end

    assign mem_clken = 1'b1;

    assign m0_waitrequest = !reset && (txn0 != TXN_NONE)
                            && !(grant_valid_c && grant_id_c == req_id_t'(0));
    assign m1_waitrequest = !reset && (txn1 != TXN_NONE)
                            && !(grant_valid_c && grant_id_c == req_id_t'(1));

    // Read response pipe: one pending read, returned the cycle after its grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= 1'b0;
            owner_q <= req_id_t'(0);
        end else begin
            pend_q  <= grant_valid_c && (gnt_txn == TXN_RD);
            owner_q <= grant_id_c;
        end
    end

    assign m0_readdatavalid = !reset && pend_q && (owner_q == req_id_t'(0));
    assign m1_readdatavalid = !reset && pend_q && (owner_q == req_id_t'(1));
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

`ifdef ONCHIP_MEM_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // Saturating grant counters; clear has priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (grant_valid_c) begin
            if (grant_id_c == req_id_t'(0) && cnt0_q != {CNT_W{1'b1}}) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (grant_id_c == req_id_t'(1) && cnt1_q != {CNT_W{1'b1}}) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_qsys_routing_controller_onchip_mem_arb.sv
// Directed bench for the on-chip memory arbiter with a behavioural byte-lane RAM.
module tb_qsys_routing_controller_onchip_mem_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [8:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        stats_clr;
    logic [15:0] grant_cnt0, grant_cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qsys_routing_controller_onchip_mem_arb dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    // Behavioural RAM: byte-lane writes, registered read data one cycle after the address.
    logic [31:0] ram [0:511];
    logic [31:0] ram_q = 32'h0;
    assign mem_readdata = ram_q;

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 32'h0;
        ram[1] = 32'h0000_0111;
        ram[2] = 32'h0000_0222;
    end

    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end

    typedef struct {
        logic        m0_rd, m0_wr;
        logic [8:0]  m0_a;
        logic [3:0]  m0_be;
        logic [31:0] m0_wd;
        logic        m1_rd, m1_wr;
        logic [8:0]  m1_a;
        logic [3:0]  m1_be;
        logic [31:0] m1_wd;
        logic        e_m0w, e_m1w, e_cs, e_we;
        logic [8:0]  e_addr;
        logic        e_m0v, e_m1v;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(
        input logic m0_rd, input logic m0_wr, input logic [8:0] m0_a, input logic [3:0] m0_be,
        input logic [31:0] m0_wd,
        input logic m1_rd, input logic m1_wr, input logic [8:0] m1_a, input logic [3:0] m1_be,
        input logic [31:0] m1_wd,
        input logic e_m0w, input logic e_m1w, input logic e_cs, input logic e_we,
        input logic [8:0] e_addr, input logic e_m0v, input logic e_m1v, input logic [31:0] e_rdata);
        vec_t v;
        v.m0_rd = m0_rd; v.m0_wr = m0_wr; v.m0_a = m0_a; v.m0_be = m0_be; v.m0_wd = m0_wd;
        v.m1_rd = m1_rd; v.m1_wr = m1_wr; v.m1_a = m1_a; v.m1_be = m1_be; v.m1_wd = m1_wd;
        v.e_m0w = e_m0w; v.e_m1w = e_m1w; v.e_cs = e_cs; v.e_we = e_we; v.e_addr = e_addr;
        v.e_m0v = e_m0v; v.e_m1v = e_m1v; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
        stats_clr = 0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        next_cycle();
        next_cycle();
        reset = 0;
    endtask

    vec_t vecs[$];

    initial begin
        idle_inputs();
        reset = 1;
        next_cycle();
        next_cycle();

        // Reset-cycle behaviour with both masters requesting
        m0_read = 1; m1_write = 1;
        @(negedge clk);
        check("rst_m0_wait", 32'(m0_waitrequest), 32'h0);
        check("rst_m1_wait", 32'(m1_waitrequest), 32'h0);
        check("rst_cs", 32'(mem_chipselect), 32'h0);
        check("rst_we", 32'(mem_write), 32'h0);
        check("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'h0);
        check("rst_cnt0", 32'(grant_cnt0), 32'h0);
        check("rst_cnt1", 32'(grant_cnt1), 32'h0);
        do_reset();

        //        m0 rd wr addr    be    wdata          m1 rd wr addr    be    wdata          m0w m1w cs we addr  v0 v1 rdata
        vecs.push_back(mk(0,1,9'h005,4'hF,32'hDEADBEEF, 0,0,9'h000,4'hF,32'h0,        0,0,1,1,9'h005, 0,0,32'h0));
        vecs.push_back(mk(1,0,9'h005,4'hF,32'h0,        1,0,9'h002,4'hF,32'h0,        1,0,1,0,9'h002, 0,0,32'h0));
        vecs.push_back(mk(1,0,9'h005,4'hF,32'h0,        0,0,9'h000,4'hF,32'h0,        0,0,1,0,9'h005, 0,1,32'h222));
        vecs.push_back(mk(0,0,9'h000,4'hF,32'h0,        0,0,9'h000,4'hF,32'h0,        0,0,0,0,9'h000, 1,0,32'hDEADBEEF));
        vecs.push_back(mk(0,0,9'h000,4'hF,32'h0,        0,1,9'h1FF,4'h3,32'h12345678, 0,0,1,1,9'h1FF, 0,0,32'h0));
        vecs.push_back(mk(0,0,9'h000,4'hF,32'h0,        1,0,9'h1FF,4'hF,32'h0,        0,0,1,0,9'h1FF, 0,0,32'h0));
        vecs.push_back(mk(0,0,9'h000,4'hF,32'h0,        0,0,9'h000,4'hF,32'h0,        0,0,0,0,9'h000, 0,1,32'h00005678));
        vecs.push_back(mk(1,1,9'h010,4'hF,32'hA5A5A5A5, 0,0,9'h000,4'hF,32'h0,        0,0,1,1,9'h010, 0,0,32'h0));
        vecs.push_back(mk(0,0,9'h000,4'hF,32'h0,        0,0,9'h000,4'hF,32'h0,        0,0,0,0,9'h000, 0,0,32'h0));
        vecs.push_back(mk(1,0,9'h010,4'hF,32'h0,        0,0,9'h000,4'hF,32'h0,        0,0,1,0,9'h010, 0,0,32'h0));
        vecs.push_back(mk(0,0,9'h000,4'hF,32'h0,        0,0,9'h000,4'hF,32'h0,        0,0,0,0,9'h000, 1,0,32'hA5A5A5A5));
        vecs.push_back(mk(0,1,9'h020,4'hA,32'h11223344, 0,0,9'h000,4'hF,32'h0,        0,0,1,1,9'h020, 0,0,32'h0));
        vecs.push_back(mk(1,0,9'h020,4'hF,32'h0,        0,0,9'h000,4'hF,32'h0,        0,0,1,0,9'h020, 0,0,32'h0));
        vecs.push_back(mk(0,0,9'h000,4'hF,32'h0,        0,0,9'h000,4'hF,32'h0,        0,0,0,0,9'h000, 1,0,32'h11003300));

        foreach (vecs[i]) begin
            m0_read = vecs[i].m0_rd; m0_write = vecs[i].m0_wr; m0_address = vecs[i].m0_a;
            m0_byteenable = vecs[i].m0_be; m0_writedata = vecs[i].m0_wd;
            m1_read = vecs[i].m1_rd; m1_write = vecs[i].m1_wr; m1_address = vecs[i].m1_a;
            m1_byteenable = vecs[i].m1_be; m1_writedata = vecs[i].m1_wd;
            @(negedge clk);
            check($sformatf("v%0d_m0_wait", i), 32'(m0_waitrequest), 32'(vecs[i].e_m0w));
            check($sformatf("v%0d_m1_wait", i), 32'(m1_waitrequest), 32'(vecs[i].e_m1w));
            check($sformatf("v%0d_cs", i), 32'(mem_chipselect), 32'(vecs[i].e_cs));
            check($sformatf("v%0d_we", i), 32'(mem_write), 32'(vecs[i].e_we));
            if (vecs[i].e_cs) check($sformatf("v%0d_addr", i), 32'(mem_address), 32'(vecs[i].e_addr));
            check($sformatf("v%0d_m0_rdv", i), 32'(m0_readdatavalid), 32'(vecs[i].e_m0v));
            check($sformatf("v%0d_m1_rdv", i), 32'(m1_readdatavalid), 32'(vecs[i].e_m1v));
            if (vecs[i].e_m0v) check($sformatf("v%0d_m0_rdata", i), m0_readdata, vecs[i].e_rdata);
            if (vecs[i].e_m1v) check($sformatf("v%0d_m1_rdata", i), m1_readdata, vecs[i].e_rdata);
            next_cycle();
        end
        idle_inputs();
        check("clken", 32'(mem_clken), 32'h1);

        // Simultaneous reads at reset exit: m0 first, then m1, responses in grant order
        do_reset();
        m0_read = 1; m0_address = 9'h001; m1_read = 1; m1_address = 9'h002;
        @(negedge clk);
        check("c0_m0_wait", 32'(m0_waitrequest), 32'h0);
        check("c0_m1_wait", 32'(m1_waitrequest), 32'h1);
        check("c0_addr", 32'(mem_address), 32'h001);
        next_cycle();
        m0_read = 0;
        @(negedge clk);
        check("c1_m1_wait", 32'(m1_waitrequest), 32'h0);
        check("c1_addr", 32'(mem_address), 32'h002);
        check("c1_m0_rdv", 32'(m0_readdatavalid), 32'h1);
        check("c1_m0_rdata", m0_readdata, 32'h111);
        check("c1_m1_rdv", 32'(m1_readdatavalid), 32'h0);
        next_cycle();
        m1_read = 0;
        @(negedge clk);
        check("c2_m1_rdv", 32'(m1_readdatavalid), 32'h1);
        check("c2_m1_rdata", m1_readdata, 32'h222);
        check("c2_m0_rdv", 32'(m0_readdatavalid), 32'h0);
        next_cycle();

        // Continuous contention for 8 cycles: strict alternation starting with m0
        do_reset();
        m0_read = 1; m0_address = 9'h001; m1_read = 1; m1_address = 9'h002;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("rr%0d_m0_wait", i), 32'(m0_waitrequest), 32'(i % 2));
            check($sformatf("rr%0d_m1_wait", i), 32'(m1_waitrequest), 32'((i + 1) % 2));
            if (i > 0) check($sformatf("rr%0d_rdv", i),
                             32'({m1_readdatavalid, m0_readdatavalid}), (i % 2 == 1) ? 32'h1 : 32'h2);
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
`ifdef ONCHIP_MEM_ARB_STATS_EN
        check("rr_cnt0", 32'(grant_cnt0), 32'h4);
        check("rr_cnt1", 32'(grant_cnt1), 32'h4);
`else
        check("rr_cnt0", 32'(grant_cnt0), 32'h0);
        check("rr_cnt1", 32'(grant_cnt1), 32'h0);
`endif
        // Clear with a same-cycle grant: clear wins
        stats_clr = 1; m1_write = 1;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("clr_cnt0", 32'(grant_cnt0), 32'h0);
        check("clr_cnt1", 32'(grant_cnt1), 32'h0);
        next_cycle();

        // Reset the cycle after a granted read: no response, priority back to m0
        m1_read = 1; m1_address = 9'h002;
        next_cycle();
        m1_read = 0; m0_read = 1; m0_address = 9'h001;
        @(negedge clk);
        check("rr_m0_grant", 32'(m0_waitrequest), 32'h0);
        next_cycle();
        reset = 1; m1_read = 1;
        @(negedge clk);
        check("rst_after_rd_m0_rdv", 32'(m0_readdatavalid), 32'h0);
        check("rst_after_rd_cs", 32'(mem_chipselect), 32'h0);
        next_cycle();
        reset = 0;
        @(negedge clk);
        check("post_rst_m0_rdv", 32'(m0_readdatavalid), 32'h0);
        check("post_rst_m0_wait", 32'(m0_waitrequest), 32'h0);
        check("post_rst_m1_wait", 32'(m1_waitrequest), 32'h1);
        next_cycle();
        idle_inputs();
        next_cycle();

`ifdef ONCHIP_MEM_ARB_STATS_EN
        // Saturation from a forced all-ones counter, then clear
        force dut.cnt0_q = 16'hFFFF;
        next_cycle();
        release dut.cnt0_q;
        m0_read = 1; m0_address = 9'h001;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("sat_cnt0", 32'(grant_cnt0), 32'hFFFF);
        stats_clr = 1;
        next_cycle();
        stats_clr = 0;
        @(negedge clk);
        check("sat_clr_cnt0", 32'(grant_cnt0), 32'h0);
        next_cycle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
